branch_result_drain: RTL

//  Reader on the output side of a conv/merge/maxpool-ReLU data-process branch. On the branch's

---
 rtl/cnn_pkg.sv | 13 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/branch_result_drain.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN branch types: drain FSM states and the branch memory read-select code.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  localparam logic [2:0] READ_SEL_MAXRELU = 3'b100;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; head word is visible combinationally on rdata.
module sync_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == CNT_W'(0));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset so it maps onto plain registers or LUT RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_result_drain.sv
// Drains the pooled-result M10K in address order onto a valid/ready stream after branch done.
// Optional DRAIN_CHECKSUM_EN adds a running sum of every accepted word on the checksum port.
module branch_result_drain
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 18,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned RESULT_WIDTH  = 24,
  parameter int unsigned RESULT_HEIGHT = 24,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic [2:0]                       read_select,
  output logic [ADDR_WIDTH-1:0]            read_address,
  input  logic [DATA_WIDTH-1:0]            read_data,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             m_last,
  output logic                             busy,
  output logic                             drain_done
`ifdef DRAIN_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] checksum
`endif
);

  localparam int unsigned NUM_WORDS = (RESULT_WIDTH / 2) * (RESULT_HEIGHT / 2);
  localparam int unsigned FCW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FW        = DATA_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

  drain_state_t          state;
  logic [ADDR_WIDTH-1:0] issue_cnt;
  logic                  req_q;
  logic                  req_last_q;
  logic                  dv_q;
  logic                  dv_last_q;
  logic [FCW-1:0]        fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FW-1:0]         fifo_rdata;
  logic                  pop_c;
  logic                  credit_ok_c;
  logic                  drained_c;

  // Two read stages can be outstanding (address presented, q returning), both hold a FIFO slot.
  assign credit_ok_c = !fifo_full &&
                       ((32'(fifo_count) + 32'(req_q) + 32'(dv_q)) < FIFO_DEPTH);
  assign pop_c       = m_valid && m_ready;
  assign drained_c   = !req_q && !dv_q &&
                       ((fifo_count == FCW'(0)) || ((fifo_count == FCW'(1)) && pop_c));

  assign m_valid          = !fifo_empty;
  assign {m_last, m_data} = fifo_rdata;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dv_q),
    .wdata ({dv_last_q, read_data}),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      read_address <= BASE;
      read_select  <= 3'b000;
      issue_cnt    <= '0;
      req_q        <= 1'b0;
      req_last_q   <= 1'b0;
      dv_q         <= 1'b0;
      dv_last_q    <= 1'b0;
      busy         <= 1'b0;
      drain_done   <= 1'b0;
    end else begin
      dv_q       <= req_q;
      dv_last_q  <= req_last_q;
      req_q      <= 1'b0;
      req_last_q <= 1'b0;
      drain_done <= 1'b0;
      case (state)
        IDLE: begin
          // The first read goes out on the accepting edge so data lands two cycles later.
          if (start) begin
            state        <= (NUM_WORDS == 1) ? FLUSH : READ;
            read_address <= BASE;
            read_select  <= READ_SEL_MAXRELU;
            busy         <= 1'b1;
            issue_cnt    <= ADDR_WIDTH'(1);
            req_q        <= 1'b1;
            req_last_q   <= (NUM_WORDS == 1);
          end
        end
        READ: begin
          if (credit_ok_c) begin
            read_address <= BASE + issue_cnt;
            issue_cnt    <= issue_cnt + ADDR_WIDTH'(1);
            req_q        <= 1'b1;
            req_last_q   <= (issue_cnt == LAST_IDX);
            if (issue_cnt == LAST_IDX) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (drained_c) begin
            state      <= DONE;
            drain_done <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          read_address <= BASE;
          read_select  <= 3'b000;
          busy         <= 1'b0;
          issue_cnt    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRAIN_CHECKSUM_EN
  localparam int unsigned CSW = DATA_WIDTH + ADDR_WIDTH;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if (pop_c) begin
      checksum <= checksum + CSW'(m_data);
    end
  end
`endif

endmodule
